scr_wr_queue: RTL and testbench
===============================

// Module: scr_wr_queue
// PURPOSE
//   Downstream of the 4-stage CPU core: snoops the core's data-write port (out_m/write_m/data_addr)
//   and queues every write that lands in the screen window, then drains them one per accepted
//   handshake to the screen-RAM writer feeding VGA. Decouples the core (which can never stall)
//   from screen-RAM port arbitration. Back-to-back writes to the same screen word are coalesced.
// PARAMETERS
//   ADDR_W       15      width of CPU data address
//   DATA_W       16      width of CPU data word
//   DEPTH        8       queue entries; power of 2, >=2
//   SCR_BASE     16384   first screen word address (0x4000)
//   SCR_WORDS    8192    screen window size in words; window = [SCR_BASE, SCR_BASE+SCR_WORDS-1]
// PORTS
//   Clock        in   1                     single clock, all state on rising edge
//   Reset        in   1                     synchronous, active-high
//   CpuWrEn      in   1                     core write strobe (write_m)
//   CpuAddr      in   ADDR_W                core write address (data_addr)
//   CpuData      in   DATA_W                core write data (out_m)
//   ScrValid     out  1                     head entry available
//   ScrAddr      out  $clog2(SCR_WORDS)     head word offset (CpuAddr - SCR_BASE)
//   ScrData      out  DATA_W                head data
//   ScrReady     in   1                     sink accepts head this cycle when ScrValid=1
//   Count        out  $clog2(DEPTH)+1       entries held
//   Full         out  1                     Count==DEPTH
//   Overflow     out  1                     sticky: a screen write was dropped
// BEHAVIOUR
//   - Reset (sync, high): Count=0, ScrValid=0, Full=0, Overflow=0, rd/wr ptrs=0; ScrAddr/ScrData=0.
//     Reset wins over any same-cycle push/pop; queued entries are discarded.
//   - Hit = CpuWrEn && SCR_BASE<=CpuAddr<SCR_BASE+SCR_WORDS (unsigned compare). Non-hits ignored.
//   - Pop = ScrValid && ScrReady. Head advances on Pop; ScrAddr/ScrData are held stable while
//     ScrValid && !ScrReady (valid may not drop without a Pop except on Reset).
//   - Coalesce = Hit && Count>=1 && offset==tail offset && !(Count==1 && Pop):
//     tail data overwritten in place, Count unchanged. Tail = most recently pushed entry.
//   - Push = Hit && !Coalesce && (!Full || Pop): writes {offset,data} at wr ptr, wr ptr++ (mod DEPTH).
//   - Drop = Hit && !Coalesce && Full && !Pop: entry lost, Overflow<=1 (sticky until Reset).
//   - Count next = Count + Push - Pop. Push+Pop same cycle when Full: accepted, Count stays DEPTH.
//   - Push+Pop with Count==1 and same offset: no coalesce (head is leaving); new entry pushed.
//   - Latency: Hit at edge N into empty queue -> ScrValid=1 after edge N (visible cycle N+1).
//     Empty queue never bypasses combinationally from CpuWrEn to ScrValid.
//   - Outputs ScrValid, Full, Count, Overflow are registered/derived from registered state only.
//   - Pointers are log2(DEPTH) bits, wrap naturally; Count carries one extra bit.
//   - Ordering: entries drain strictly in push order; coalescing never reorders.
// TESTING
//   1 Reset; ScrReady=0; writes 0x4000<=0x1111, 0x4001<=0x2222 -> Count=2, head ScrAddr=0,
//     ScrData=0x1111 held stable; ScrReady=1 -> drains 0/0x1111 then 1/0x2222, Count=0.
//   2 Writes to 0x3FFF, 0x6000, and CpuWrEn=0 with addr 0x4005 -> Count stays 0, ScrValid=0.
//   3 ScrReady=0; writes 0x4010<=A then 0x4010<=B -> Count=1, ScrData=B; then 0x4011<=C,
//     0x4010<=D -> Count=3 (no coalesce with non-tail entry).
//   4 ScrReady=0; 9 distinct screen writes with DEPTH=8 -> Full=1, 9th dropped, Overflow=1;
//     drain all -> 8 entries in order, Overflow stays 1 until Reset.
//   5 Full, same cycle Pop and new distinct Hit -> Count stays 8, new entry drained last; Count==1
//     with Pop and same-offset Hit -> Count stays 1, new data drained next.
//   6 Reset asserted mid-drain with Count=5 -> next cycle Count=0, ScrValid=0, Overflow=0.

Source files
------------

// File: rtl/scr_wr_queue.sv
// scr_wr_queue: snoops CPU data writes, queues those that land in the screen
// window and drains them in order to the screen-RAM writer. Consecutive writes
// to the same screen word merge into the tail entry.
module scr_wr_queue #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int SCR_BASE  = 16384,
  parameter int SCR_WORDS = 8192,
  localparam int OFF_W    = $clog2(SCR_WORDS),
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_cpu_wr_en,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_data,
  output logic              o_scr_valid,
  output logic [OFF_W-1:0]  o_scr_addr,
  output logic [DATA_W-1:0] o_scr_data,
  input  logic              i_scr_ready,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_overflow
);

  // Window bounds carry one extra bit so the upper bound never wraps.
  localparam logic [ADDR_W:0]  LP_LO       = (ADDR_W+1)'(SCR_BASE);
  localparam logic [ADDR_W:0]  LP_HI       = (ADDR_W+1)'(SCR_BASE + SCR_WORDS);
  localparam logic [OFF_W-1:0] LP_BASE_OFF = OFF_W'(SCR_BASE);
  localparam logic [CNT_W-1:0] LP_DEPTH    = CNT_W'(DEPTH);

  logic [OFF_W-1:0]  r_mem_off  [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic [ADDR_W:0]   w_addr_ext;
  logic [OFF_W-1:0]  w_offset;
  logic [PTR_W-1:0]  w_tail_ptr;
  logic              w_valid;
  logic              w_full;
  logic              w_hit;
  logic              w_pop;
  logic              w_coalesce;
  logic              w_push;
  logic              w_drop;
  logic [CNT_W-1:0]  w_count_nxt;

  assign w_addr_ext = {1'b0, i_cpu_addr};
  // Offset modulo the window size; only meaningful when the address is a hit.
  assign w_offset   = i_cpu_addr[OFF_W-1:0] - LP_BASE_OFF;
  assign w_tail_ptr = r_wr_ptr - PTR_W'(1);
  assign w_valid    = (r_count != {CNT_W{1'b0}});
  assign w_full     = (r_count == LP_DEPTH);

  // Classify this cycle's write and compute the next occupancy.
  always_comb begin
    w_hit       = 1'b0;
    w_pop       = 1'b0;
    w_coalesce  = 1'b0;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    w_count_nxt = r_count;

    w_hit = i_cpu_wr_en && (w_addr_ext >= LP_LO) && (w_addr_ext < LP_HI);
    w_pop = w_valid && i_scr_ready;

    // A lone entry that is leaving this cycle cannot absorb the new write.
    if (w_hit && w_valid && (r_mem_off[w_tail_ptr] == w_offset) &&
        !((r_count == CNT_W'(1)) && w_pop)) begin
      w_coalesce = 1'b1;
    end else begin
      w_coalesce = 1'b0;
    end

    w_push = w_hit && !w_coalesce && (!w_full || w_pop);
    w_drop = w_hit && !w_coalesce && w_full && !w_pop;

    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Queue storage, pointers, occupancy and sticky overflow flag.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_off[i]  <= {OFF_W{1'b0}};
        r_mem_data[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (w_push) begin
        r_mem_off[r_wr_ptr]  <= w_offset;
        r_mem_data[r_wr_ptr] <= i_cpu_data;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end else if (w_coalesce) begin
        r_mem_data[w_tail_ptr] <= i_cpu_data;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_count <= w_count_nxt;
    end
  end

  // Head is presented straight from storage, so it stays put until popped.
  assign o_scr_valid = w_valid;
  assign o_scr_addr  = r_mem_off[r_rd_ptr];
  assign o_scr_data  = r_mem_data[r_rd_ptr];
  assign o_count     = r_count;
  assign o_full      = w_full;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_scr_wr_queue.sv
// tb_scr_wr_queue: directed scenarios plus a random phase, every cycle compared
// against a queue-based model of the screen write queue.
module tb_scr_wr_queue;

  localparam int DEPTH = 8;
  localparam int BASE  = 16384;
  localparam int WORDS = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [14:0] addr;
  logic [15:0] data;
  logic        ready;
  logic        scr_valid;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic [3:0]  count;
  logic        full;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [12:0] off;
    logic [15:0] dat;
  } ent_t;

  ent_t m_q[$];
  bit   m_ovf;

  always #5 clk = ~clk;

  scr_wr_queue dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_cpu_wr_en(wr_en),
    .i_cpu_addr (addr),
    .i_cpu_data (data),
    .o_scr_valid(scr_valid),
    .o_scr_addr (scr_addr),
    .o_scr_data (scr_data),
    .i_scr_ready(ready),
    .o_count    (count),
    .o_full     (full),
    .o_overflow (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all DUT outputs with the model's view of the queue.
  task automatic check_state();
    chk("count", 32'(count), 32'(m_q.size()));
    chk("valid", 32'(scr_valid), 32'(m_q.size() != 0));
    chk("full", 32'(full), 32'(m_q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_q.size() != 0) begin
      chk("head_addr", 32'(scr_addr), 32'(m_q[0].off));
      chk("head_data", 32'(scr_data), 32'(m_q[0].dat));
    end
  endtask

  // One clock with the given inputs; model follows the queue rules directly.
  task automatic step(input logic w, input logic [14:0] a, input logic [15:0] d, input logic r);
    bit   hit;
    bit   pop;
    bit   merge;
    int   ai;
    ent_t e;
    wr_en = w; addr = a; data = d; ready = r; rst = 1'b0;
    ai    = int'(a);
    hit   = w && (ai >= BASE) && (ai < BASE + WORDS);
    pop   = (m_q.size() > 0) && r;
    e.off = 13'(ai - BASE);
    e.dat = d;
    merge = hit && (m_q.size() >= 1) && (m_q[$].off == e.off) && !(m_q.size() == 1 && pop);
    if (pop) void'(m_q.pop_front());
    if (merge) m_q[$].dat = d;
    else if (hit) begin
      if (m_q.size() < DEPTH) m_q.push_back(e);
      else m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b1; addr = 15'h4003; data = 16'hDEAD; ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; wr_en = 1'b0; ready = 1'b0;
    m_q.delete();
    m_ovf = 1'b0;
    check_state();
    chk("rst_addr", 32'(scr_addr), 32'h0);
    chk("rst_data", 32'(scr_data), 32'h0);
  endtask

  initial begin
    int sel;
    logic [14:0] ra;
    rst = 1'b1; wr_en = 1'b0; addr = 15'h0; data = 16'h0; ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Basic enqueue, head held while not ready, then ordered drain.
    step(1'b1, 15'h4000, 16'h1111, 1'b0);
    chk("t1_latency_valid", 32'(scr_valid), 32'h1);
    step(1'b1, 15'h4001, 16'h2222, 1'b0);
    step(1'b0, 15'h0000, 16'h0000, 1'b0);
    chk("t1_hold_data", 32'(scr_data), 32'h1111);
    step(1'b0, 15'h0000, 16'h0000, 1'b1);
    chk("t1_second_head", 32'(scr_data), 32'h2222);
    step(1'b0, 15'h0000, 16'h0000, 1'b1);
    chk("t1_empty", 32'(count), 32'h0);

    // Writes outside the window or without strobe are ignored.
    step(1'b1, 15'h3FFF, 16'hAAAA, 1'b0);
    step(1'b1, 15'h6000, 16'hBBBB, 1'b0);
    step(1'b0, 15'h4005, 16'hCCCC, 1'b0);
    chk("t2_no_valid", 32'(scr_valid), 32'h0);

    // Coalescing only with the tail.
    step(1'b1, 15'h4010, 16'h000A, 1'b0);
    step(1'b1, 15'h4010, 16'h000B, 1'b0);
    chk("t3_coalesce_cnt", 32'(count), 32'h1);
    chk("t3_coalesce_dat", 32'(scr_data), 32'h000B);
    step(1'b1, 15'h4011, 16'h000C, 1'b0);
    step(1'b1, 15'h4010, 16'h000D, 1'b0);
    chk("t3_nontail_cnt", 32'(count), 32'h3);

    // Fill past capacity, then drain in order; overflow stays set.
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 15'(16'h4020 + i), 16'(16'h0100 + i), 1'b0);
    chk("t4_full", 32'(full), 32'h1);
    chk("t4_overflow", 32'(overflow), 32'h1);
    for (int i = 0; i < 8; i++) begin
      chk("t4_drain_order", 32'(scr_data), 32'(16'h0100 + i));
      step(1'b0, 15'h0000, 16'h0000, 1'b1);
    end
    chk("t4_ovf_sticky", 32'(overflow), 32'h1);

    // Push and pop together when full, and at Count==1 with matching offset.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 15'(16'h4100 + i), 16'(16'h0200 + i), 1'b0);
    step(1'b1, 15'h4200, 16'hBEEF, 1'b1);
    chk("t5_full_pushpop", 32'(count), 32'h8);
    for (int i = 0; i < 7; i++) step(1'b0, 15'h0000, 16'h0000, 1'b1);
    chk("t5_last_entry", 32'(scr_data), 32'hBEEF);
    step(1'b1, 15'h4200, 16'hCAFE, 1'b1);
    chk("t5_one_cnt", 32'(count), 32'h1);
    chk("t5_one_dat", 32'(scr_data), 32'hCAFE);

    // Reset in the middle of a drain.
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 15'(16'h4300 + i), 16'(16'h0300 + i), 1'b0);
    step(1'b0, 15'h0000, 16'h0000, 1'b1);
    step(1'b0, 15'h0000, 16'h0000, 1'b1);
    chk("t6_pre_cnt", 32'(count), 32'h5);
    do_reset();

    // Random traffic focused on a few nearby words to exercise merging and full.
    for (int c = 0; c < 1500; c++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        7:       ra = 15'h3FFF;
        8:       ra = 15'h6000;
        9:       ra = 15'($urandom_range(0, 32767));
        default: ra = 15'(16'h4000 + $urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 9) < 7, ra, 16'($urandom),
                $urandom_range(0, 99) < ((c / 250) % 2 == 0 ? 30 : 70));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
